// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_pkg -- shared FSM, size and owner encodings.  Rev 1.0
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_HALF) return addr_lo[0];
    if (size[1])         return addr_lo != 2'b00;
    return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// mem_lane_align -- store lane mask/replication and load extract/extend.  Rev 1.0
// ============================================================================
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_mask_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  always_comb begin
    st_mask_o  = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_mask_o  = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_mask_o  = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    w_ld_byte = ld_rdata_i[7:0];
      2'd1:    w_ld_byte = ld_rdata_i[15:8];
      2'd2:    w_ld_byte = ld_rdata_i[23:16];
      default: w_ld_byte = ld_rdata_i[31:24];
    endcase
    w_ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
  end

  always_comb begin
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & w_ld_half[15]}}, w_ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter -- fetch/data sharing of one fixed-latency memory port.  Rev 1.0
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY    = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [1:0]  i_d_size,
  input  logic        i_d_unsigned,
  output logic        o_d_ready,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata
);

  localparam int c_LAT_W   = $clog2(MEM_LATENCY + 2);
  localparam int c_BURST_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [c_LAT_W-1:0]   c_LAT_LOAD  = c_LAT_W'(MEM_LATENCY);
  localparam logic [c_LAT_W-1:0]   c_LAT_LAST  = c_LAT_W'(2);
  localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(MAX_DATA_BURST);

  state_e               state_q, state_d;
  logic [c_LAT_W-1:0]   lat_q, lat_d;
  logic [c_BURST_W-1:0] burst_q, burst_d;
  logic                 owner_q, wen_q, err_q, uns_q;
  logic [1:0]           size_q;
  logic [31:0]          addr_q, wdata_q;
  logic [3:0]           mask_q;

  logic        w_grant_d, w_grant_if, w_idle, w_d_acc, w_if_acc, w_d_mis;
  logic [3:0]  w_st_mask;
  logic [31:0] w_st_wdata, w_ld_data;

  // Data wins unless fetch has waited through a full data burst.
  assign w_grant_d  = i_d_req & ~(i_if_req & (burst_q == c_BURST_MAX));
  assign w_grant_if = i_if_req & ~w_grant_d;
  assign w_idle     = i_rst_n & (state_q == IDLE);
  assign o_d_ready  = w_idle & w_grant_d;
  assign o_if_ready = w_idle & w_grant_if;
  assign w_d_acc    = o_d_ready;
  assign w_if_acc   = o_if_ready;
  assign w_d_mis    = is_misaligned(i_d_size, i_d_addr[1:0]);

  mem_lane_align u_align (
    .st_size_i     (i_d_size),
    .st_addr_lo_i  (i_d_addr[1:0]),
    .st_wdata_i    (i_d_wdata),
    .st_mask_o     (w_st_mask),
    .st_wdata_o    (w_st_wdata),
    .ld_size_i     (size_q),
    .ld_addr_lo_i  (addr_q[1:0]),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (i_mem_rdata),
    .ld_data_o     (w_ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (w_d_acc && w_d_mis)      state_d = RESP;
        else if (w_d_acc || w_if_acc) state_d = ISSUE;
      end
      ISSUE: begin
        lat_d   = c_LAT_LOAD;
        state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == c_LAT_LAST) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    if (!i_if_req || w_if_acc)                      burst_d = '0;
    else if (w_d_acc && (burst_q != c_BURST_MAX))  burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q <= OWN_IF;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (w_d_acc) begin
      owner_q <= OWN_D;
      wen_q   <= i_d_wen;
      err_q   <= w_d_mis;
      uns_q   <= i_d_unsigned;
      size_q  <= i_d_size;
      addr_q  <= i_d_addr;
      wdata_q <= i_d_wen ? w_st_wdata : 32'h0;
      mask_q  <= i_d_wen ? w_st_mask : 4'b0000;
    end else if (w_if_acc) begin
      owner_q <= OWN_IF;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_WORD;
      addr_q  <= i_if_addr;
      wdata_q <= 32'h0;
      mask_q  <= 4'b0000;
    end
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_mask  = 4'b0000;
    o_if_valid  = 1'b0;
    o_if_rdata  = 32'h0;
    o_d_valid   = 1'b0;
    o_d_rdata   = 32'h0;
    o_d_err     = 1'b0;
    case (state_q)
      ISSUE: begin
        o_mem_req   = 1'b1;
        o_mem_wen   = wen_q;
        o_mem_addr  = {addr_q[31:2], 2'b00};
        o_mem_wdata = wdata_q;
        o_mem_mask  = mask_q;
      end
      RESP: begin
        if (owner_q == OWN_IF) begin
          o_if_valid = 1'b1;
          o_if_rdata = i_mem_rdata;
        end else begin
          o_d_valid = 1'b1;
          o_d_err   = err_q;
          if (!err_q && !wen_q) o_d_rdata = w_ld_data;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between two requesters.
- The fetch stage issues instruction reads; the memory stage issues data loads and stores.
- Data accesses take the control decoder's size select (sbhw_sel/lbhw_sel) and l_unsigned.
- The block sequences each access, generates byte masks, aligns store data, and extracts and extends load data. Data has priority over fetch, with a bounded-starvation guarantee for fetch.

Parameters:
- MEM_LATENCY, 2, cycles from o_mem_req to i_mem_rdata valid (>=1).
- MAX_DATA_BURST, 4, max consecutive data grants while fetch is pending (>=1).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_if_req  in  1  fetch request
- i_if_addr  in  32  fetch byte address; bits [1:0] ignored
- o_if_ready  out  1  fetch request accepted this cycle
- o_if_valid  out  1  one-cycle pulse, instruction returned
- o_if_rdata  out  32  instruction word, valid with o_if_valid
- i_d_req  in  1  data request
- i_d_wen  in  1  1 = store, 0 = load
- i_d_addr  in  32  data byte address
- i_d_wdata  in  32  store data, LSB-justified
- i_d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_d_unsigned  in  1  load zero-extend when 1
- o_d_ready  out  1  data request accepted this cycle
- o_d_valid  out  1  one-cycle pulse, load data or store completion
- o_d_rdata  out  32  aligned, extended load data; 0 for stores and errors
- o_d_err  out  1  misaligned access, qualified by o_d_valid
- o_mem_req  out  1  one-cycle memory strobe
- o_mem_wen  out  1  memory write
- o_mem_addr  out  32  word address, bits [1:0] forced 0
- o_mem_wdata  out  32  lane-replicated store data
- o_mem_mask  out  4  byte enables; 0000 for reads
- i_mem_rdata  in  32  memory read word, valid MEM_LATENCY cycles after o_mem_req

Behaviour:
- Reset and reset mid-operation:
  - While i_rst_n is low (asynchronous assertion), state is IDLE, the burst counter is 0, and the latency counter is 0.
  - All outputs are 0.
  - An in-flight access is dropped and no valid pulse is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - o_if_ready/o_d_ready are driven combinationally for the arbitration winner only.
  - Acceptance occurs when req and ready are both high, at cycle T. The block captures the request and moves to ISSUE.
- Arbitration in IDLE:
  - Data wins if i_d_req is high, unless i_if_req is high and burst_cnt == MAX_DATA_BURST, in which case fetch wins.
  - burst_cnt increments on a data grant made while i_if_req is high.
  - burst_cnt clears on a fetch grant or on any cycle where i_if_req is low.
  - burst_cnt saturates at MAX_DATA_BURST.
- ISSUE (T+1):
  - o_mem_req = 1 with registered addr, wen, mask, and wdata.
  - Latency counter loads MEM_LATENCY. Go to WAIT.
- WAIT: decrement each cycle. When the counter reaches 1, go to RESP.
- RESP (T+1+MEM_LATENCY):
  - Sample i_mem_rdata and pulse the owner's valid for one cycle.
  - Next state is IDLE. Throughput is one access per MEM_LATENCY+2 cycles; ready is never asserted in ISSUE, WAIT, or RESP.
- Misaligned data access (half with addr[0]=1, or word with addr[1:0] != 0):
  - Accepted normally, but no memory strobe is issued.
  - Goes IDLE -> RESP directly.
  - o_d_valid = 1, o_d_err = 1, o_d_rdata = 0 at T+1.
  - Fetch never errors.
- Store lane rules:
  - Byte: mask = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: mask = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: mask = 1111.
- Load extraction:
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - Result is sign-extended, or zero-extended when i_d_unsigned = 1. Word is passed through.
- Stores return o_d_valid at RESP with o_d_rdata = 0.
- Request signals only need to be held through the acceptance cycle. Changes after acceptance have no effect.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - size constants SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - owner encoding OWN_IF / OWN_D.
- One combinational sub-module, mem_lane_align, holds the store mask/replicate and load extract/extend logic. It is reused by a future cache.

Test Plan:
- Fetch only, addr 0x100, mem returns 0x00500093, MEM_LATENCY = 2 -> o_if_ready at T; o_mem_req at T+1 with o_mem_addr 0x100, mask 0000; o_if_valid with 0x00500093 at T+3.
- Simultaneous if_req and d_req (load word at 0x200) -> data granted first; fetch granted at the next IDLE.
- i_if_req held high with 6 back-to-back d_req, MAX_DATA_BURST = 4 -> grant order D, D, D, D, IF, D, D.
- Store byte 0xAB to 0x203 -> mask 1000, wdata 0xABABABAB, addr 0x200; store half to 0x202 -> mask 1100.
- Load byte at 0x201 with mem 0x0000_8000 -> o_d_rdata 0xFFFFFF80; same with i_d_unsigned = 1 -> 0x00000080.
- Half load at 0x203 -> o_d_err = 1 at T+1 with no o_mem_req. Reset asserted during WAIT -> outputs 0 immediately and no o_d_valid follows.
